// File: rtl/touch_pkg.sv
// rtl/touch_pkg.sv - shared encodings for the touch key LED mode controller.
package touch_pkg;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_FAST  = 2'd3;

    localparam int FAST_DIV = 4;

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        HELD,
        GAP,
        DTAP_HOLD
    } touch_state_t;

endpackage

// File: rtl/touch_debounce.sv
// rtl/touch_debounce.sv - two-flop synchroniser and debouncer for the active-low touch key.
module touch_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic touch_key,
    output logic key_stable,
    output logic key_press,
    output logic key_release
);

    localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DW-1:0] DB_TERM = DW'(DEBOUNCE_CYC - 1);

    logic          sync_1;
    logic          sync_2;
    logic [DW-1:0] db_cnt;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync_1      <= 1'b1;
            sync_2      <= 1'b1;
            key_stable  <= 1'b1;
            db_cnt      <= '0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            sync_1      <= touch_key;
            sync_2      <= sync_1;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            if (sync_2 != key_stable) begin
                // The edge strobes fire in the same cycle key_stable takes its new value.
                if (db_cnt == DB_TERM) begin
                    key_stable  <= sync_2;
                    db_cnt      <= '0;
                    key_press   <= ~sync_2;
                    key_release <= sync_2;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/touch_led_mode_ctrl.sv
// rtl/touch_led_mode_ctrl.sv - touch gesture classifier driving the LED mode register and blinker.
// Double-tap detection (GAP/DTAP_HOLD, FAST mode) is built only with TOUCH_DTAP_EN defined.
module touch_led_mode_ctrl #(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int LONG_CYC     = 50_000_000,
    parameter int DTAP_GAP     = 15_000_000,
    parameter int BLINK_HALF   = 12_500_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       touch_key,
    output logic       led,
    output logic [1:0] led_mode,
    output logic       tap_pulse,
    output logic       long_pulse,
    output logic       dtap_pulse
);

    import touch_pkg::*;

    // PRESSED and GAP never overlap, so one timer measures both the hold and the gap.
    localparam int TMR_MAX = (LONG_CYC > DTAP_GAP) ? LONG_CYC : DTAP_GAP;
    localparam int TW      = $clog2(TMR_MAX);
    localparam logic [TW-1:0] LONG_TERM = TW'(LONG_CYC - 1);

    localparam int BW = $clog2(BLINK_HALF);
    localparam logic [BW-1:0] BLINK_TERM = BW'(BLINK_HALF - 1);
    localparam logic [BW-1:0] FAST_TERM  = BW'(BLINK_HALF / FAST_DIV - 1);

    logic          key_stable;
    logic          key_press;
    logic          key_release;
    touch_state_t  state;
    logic [TW-1:0] tmr;
    logic [1:0]    mode_seen;
    logic [BW-1:0] blink_cnt;

    touch_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .touch_key  (touch_key),
        .key_stable (key_stable),
        .key_press  (key_press),
        .key_release(key_release)
    );

`ifdef TOUCH_DTAP_EN
    localparam logic [TW-1:0] GAP_TERM = TW'(DTAP_GAP - 1);
`else
    assign dtap_pulse = 1'b0;
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            tmr        <= '0;
            tap_pulse  <= 1'b0;
            long_pulse <= 1'b0;
`ifdef TOUCH_DTAP_EN
            dtap_pulse <= 1'b0;
`endif
        end else begin
            tap_pulse  <= 1'b0;
            long_pulse <= 1'b0;
`ifdef TOUCH_DTAP_EN
            dtap_pulse <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (key_press) begin
                        state <= PRESSED;
                        tmr   <= '0;
                    end
                end
                PRESSED: begin
                    if (key_release) begin
`ifdef TOUCH_DTAP_EN
                        state <= GAP;
                        tmr   <= '0;
`else
                        tap_pulse <= 1'b1;
                        state     <= IDLE;
`endif
                    end else if (tmr == LONG_TERM) begin
                        long_pulse <= 1'b1;
                        state      <= HELD;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                HELD: begin
                    if (key_stable) state <= IDLE;
                end
`ifdef TOUCH_DTAP_EN
                GAP: begin
                    // A second press landing on the last gap cycle still counts as a double tap.
                    if (key_press) begin
                        dtap_pulse <= 1'b1;
                        state      <= DTAP_HOLD;
                    end else if (tmr == GAP_TERM) begin
                        tap_pulse <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                DTAP_HOLD: begin
                    if (key_stable) state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            led_mode <= MODE_OFF;
        end else if (dtap_pulse) begin
            led_mode <= MODE_FAST;
        end else if (long_pulse) begin
            led_mode <= (led_mode == MODE_BLINK || led_mode == MODE_FAST) ? MODE_ON : MODE_BLINK;
        end else if (tap_pulse) begin
            led_mode <= (led_mode == MODE_OFF) ? MODE_ON : MODE_OFF;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mode_seen <= MODE_OFF;
            blink_cnt <= '0;
            led       <= 1'b0;
        end else begin
            mode_seen <= led_mode;
            // A fresh mode always starts its blink phase lit.
            if (led_mode != mode_seen) begin
                blink_cnt <= '0;
                led       <= (led_mode != MODE_OFF);
            end else begin
                case (led_mode)
                    MODE_OFF: led <= 1'b0;
                    MODE_ON:  led <= 1'b1;
                    default: begin
                        if (blink_cnt == ((led_mode == MODE_FAST) ? FAST_TERM : BLINK_TERM)) begin
                            blink_cnt <= '0;
                            led       <= ~led;
                        end else begin
                            blink_cnt <= blink_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_touch_led_mode_ctrl.sv
// tb/tb_touch_led_mode_ctrl.sv - self-checking bench for touch_led_mode_ctrl against a gesture-level model.
module tb_touch_led_mode_ctrl;

    localparam int D    = 4;
    localparam int LC   = 20;
    localparam int DG   = 10;
    localparam int BH   = 8;
    localparam int MAXC = 40000;

    logic       sys_clk   = 1'b0;
    logic       sys_rst   = 1'b1;
    logic       touch_key = 1'b1;
    logic       led;
    logic [1:0] led_mode;
    logic       tap_pulse;
    logic       long_pulse;
    logic       dtap_pulse;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int base   = 0;

    // channels: 0 tap, 1 long, 2 dtap, 3 led_mode, 4 led
    logic [1:0] rec_v [5][MAXC];
    logic [1:0] exp_v [5][MAXC];
    int         emode  [MAXC];
    int         estart [MAXC];

    typedef struct {
        bit lvl;
        int start;
        int len;
    } seg_t;
    seg_t segs[$];

    touch_led_mode_ctrl #(
        .DEBOUNCE_CYC(D),
        .LONG_CYC    (LC),
        .DTAP_GAP    (DG),
        .BLINK_HALF  (BH)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .touch_key (touch_key),
        .led       (led),
        .led_mode  (led_mode),
        .tap_pulse (tap_pulse),
        .long_pulse(long_pulse),
        .dtap_pulse(dtap_pulse)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        cyc = cyc + 1;
        #1;
        if (cyc < MAXC) begin
            rec_v[0][cyc] = {1'b0, tap_pulse};
            rec_v[1][cyc] = {1'b0, long_pulse};
            rec_v[2][cyc] = {1'b0, dtap_pulse};
            rec_v[3][cyc] = led_mode;
            rec_v[4][cyc] = {1'b0, led};
        end
    end

    function automatic string ch_name(input int ch);
        case (ch)
            0: return "tap_pulse";
            1: return "long_pulse";
            2: return "dtap_pulse";
            3: return "led_mode";
            default: return "led";
        endcase
    endfunction

    // Called at a negedge; the level is sampled by the DUT from the next posedge on.
    task automatic drive(input bit lvl, input int len);
        seg_t s;
        s.lvl = lvl;
        s.start = cyc + 1;
        s.len = len;
        segs.push_back(s);
        for (int i = 0; i < len; i++) begin
            touch_key = lvl;
            @(negedge sys_clk);
        end
    endtask

    task automatic do_reset(input int n);
        sys_rst = 1'b1;
        repeat (n) @(negedge sys_clk);
        sys_rst = 1'b0;
        segs.delete();
        base = cyc + 1;
    endtask

    task automatic mark(input int ch, input int t, input int last);
        if (t <= last) exp_v[ch][t] = 2'd1;
    endtask

    // Derive debounced edges and gestures from the driven segments, then compare every cycle.
    task automatic check_scn(input string name);
        int ps[$];
        int rs[$];
        int last;
        int n;
        int m;
        int pm;
        int c0;
        int half;
        int bad;
        last = cyc;
        for (int c = base - 1; c <= last; c++)
            for (int ch = 0; ch < 5; ch++) exp_v[ch][c] = 2'd0;
        for (int i = 0; i < segs.size(); i++) begin
            if (segs[i].lvl == 1'b0 && segs[i].len >= D && i + 1 < segs.size()) begin
                ps.push_back(segs[i].start + D + 1);
                rs.push_back(segs[i + 1].start + D + 1);
            end
        end
        n = ps.size();
        for (int i = 0; i < n; i++) begin
            if (rs[i] - ps[i] > LC) begin
                mark(1, ps[i] + LC + 1, last);
`ifdef TOUCH_DTAP_EN
            end else if (i + 1 < n && ps[i + 1] - rs[i] <= DG) begin
                mark(2, ps[i + 1] + 1, last);
                i++;
            end else begin
                mark(0, rs[i] + 1 + DG, last);
            end
`else
            end else begin
                mark(0, rs[i] + 1, last);
            end
`endif
        end
        emode[base - 1]  = 0;
        estart[base - 1] = base - 1;
        for (int c = base; c <= last; c++) begin
            m = emode[c - 1];
            if (exp_v[2][c - 1] == 2'd1) m = 3;
            else if (exp_v[1][c - 1] == 2'd1) m = (m >= 2) ? 1 : 2;
            else if (exp_v[0][c - 1] == 2'd1) m = (m == 0) ? 1 : 0;
            emode[c]  = m;
            estart[c] = (m != emode[c - 1]) ? c : estart[c - 1];
            exp_v[3][c] = 2'(m);
            pm = emode[c - 1];
            c0 = estart[c - 1];
            half = (pm == 3) ? BH / 4 : BH;
            if (pm == 0) exp_v[4][c] = 2'd0;
            else if (pm == 1) exp_v[4][c] = 2'd1;
            else exp_v[4][c] = ((((c - c0 - 1) / half) % 2) == 0) ? 2'd1 : 2'd0;
        end
        for (int ch = 0; ch < 5; ch++) begin
            bad = -1;
            for (int c = base; c <= last; c++)
                if (bad < 0 && rec_v[ch][c] !== exp_v[ch][c]) bad = c;
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL %s.%s at cycle %0d: got %0d want %0d", name, ch_name(ch), bad - base,
                         rec_v[ch][bad], exp_v[ch][bad]);
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if (led !== 1'b0) begin errors++; $display("FAIL reset.led got %0b want 0", led); end
        checks++;
        if (led_mode !== 2'd0) begin errors++; $display("FAIL reset.led_mode got %0d want 0", led_mode); end
        checks++;
        if ({tap_pulse, long_pulse, dtap_pulse} !== 3'b000) begin
            errors++;
            $display("FAIL reset.pulses got %b want 000", {tap_pulse, long_pulse, dtap_pulse});
        end
    endtask

    task automatic test_glitch();
        do_reset(2);
        drive(1, 10); drive(0, 1); drive(1, 10); drive(0, 3); drive(1, 20);
        check_scn("glitch");
    endtask

    task automatic test_tap();
        do_reset(2);
        drive(1, 8); drive(0, 10); drive(1, 30); drive(0, 10); drive(1, 40);
        check_scn("tap");
    endtask

    task automatic test_long();
        do_reset(2);
        drive(1, 8); drive(0, 40); drive(1, 30); drive(0, 40); drive(1, 40);
        check_scn("long");
    endtask

    task automatic test_dtap();
        do_reset(2);
        drive(1, 8);
        drive(0, 10); drive(1, 5);  drive(0, 10); drive(1, 30);
        drive(0, 10); drive(1, 10); drive(0, 40); drive(1, 30);
        drive(0, 10); drive(1, 11); drive(0, 10); drive(1, 40);
        check_scn("dtap");
    endtask

    task automatic test_random(input int n);
        int lo;
        int hi;
        do_reset(2);
        drive(1, 8);
        for (int g = 0; g < n; g++) begin
            lo = ($urandom_range(1, 0) == 1) ? int'($urandom_range(18, 4)) : int'($urandom_range(45, 23));
            hi = int'($urandom_range(24, 4));
            drive(0, lo);
            drive(1, hi);
        end
        drive(1, 40);
        check_scn("random");
    endtask

    task automatic test_reset_mid();
        do_reset(2);
        drive(1, 8); drive(0, 40); drive(1, 25);
        checks++;
        if (led_mode !== 2'd2) begin errors++; $display("FAIL pre_reset.led_mode got %0d want 2", led_mode); end
        sys_rst = 1'b1;
        #1;
        checks++;
        if (led !== 1'b0) begin errors++; $display("FAIL mid_blink_reset.led got %0b want 0", led); end
        checks++;
        if (led_mode !== 2'd0) begin errors++; $display("FAIL mid_blink_reset.led_mode got %0d want 0", led_mode); end
        do_reset(1);
        drive(1, 8); drive(0, 15);
        sys_rst = 1'b1;
        #1;
        checks++;
        if ({tap_pulse, long_pulse, dtap_pulse} !== 3'b000) begin
            errors++;
            $display("FAIL mid_press_reset.pulses got %b want 000", {tap_pulse, long_pulse, dtap_pulse});
        end
        do_reset(3);
        drive(0, 30); drive(1, 40);
        check_scn("held_through_reset");
    endtask

    initial begin
        @(negedge sys_clk);
        test_reset();
        do_reset(1);
        test_glitch();
        test_tap();
        test_long();
        test_dtap();
        test_random(8);
        test_random(10);
        test_random(12);
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
